// File: rtl/boron_pkg.sv
// Shared BORON constants: block geometry, 4-bit S-box tables and the sequencer state enum.
// The inverse table is only referenced when BORON_SBOX_INV_EN is defined.
package boron_pkg;

  localparam int BLOCK_W   = 64;
  localparam int NIB_W     = 4;
  localparam int NIBBLES   = 16;
  localparam int NIB_IDX_W = $clog2(NIBBLES);

  localparam logic [NIB_W-1:0] SBOX_FWD [NIBBLES] = '{
    4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
    4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
  };

  localparam logic [NIB_W-1:0] SBOX_INV [NIBBLES] = '{
    4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
    4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/boron_sbox_seq_if.sv
// Handshake bundle for boron_sbox_seq: input valid/ready, output valid/ready, busy.
// The mode wire exists only when BORON_SBOX_INV_EN is defined.
interface boron_sbox_seq_if;
  import boron_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
`ifdef BORON_SBOX_INV_EN
  logic               mode;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               busy;

  modport master (
`ifdef BORON_SBOX_INV_EN
    output mode,
`endif
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
`ifdef BORON_SBOX_INV_EN
    input  mode,
`endif
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/boron_sbox4.sv
// Combinational 4-bit BORON substitution; dir=0 forward, dir=1 inverse.
// Tie dir low to leave only the forward table after constant propagation.
module boron_sbox4
  import boron_pkg::*;
(
  input  logic [NIB_W-1:0] din,
  input  logic             dir,
  output logic [NIB_W-1:0] dout
);

  assign dout = dir ? SBOX_INV[din] : SBOX_FWD[din];

endmodule

// File: rtl/boron_sbox_seq.sv
// Sequenced BORON S-box layer: substitutes SB_PER_CYC nibbles per cycle over 16/SB_PER_CYC beats.
// Define BORON_SBOX_INV_EN to add the mode input and inverse-table selection.
module boron_sbox_seq
  import boron_pkg::*;
#(
  parameter int SB_PER_CYC = 4
)
(
  input  logic               clk,
  input  logic               rst,
  boron_sbox_seq_if.slave    bus
);

  localparam int N     = NIBBLES / SB_PER_CYC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(SB_PER_CYC == 1 || SB_PER_CYC == 2 || SB_PER_CYC == 4 ||
          SB_PER_CYC == 8 || SB_PER_CYC == 16)) begin : g_bad_param
      $error("boron_sbox_seq: SB_PER_CYC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [BLOCK_W-1:0] work, work_nxt;
  logic               last_beat;
  logic               dir;

  logic [NIB_IDX_W-1:0] nib_idx [SB_PER_CYC];
  logic [NIB_W-1:0]     sb_in   [SB_PER_CYC];
  logic [NIB_W-1:0]     sb_out  [SB_PER_CYC];

`ifdef BORON_SBOX_INV_EN
  logic mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mode_q <= 1'b0;
    else if (state == IDLE && bus.in_valid)
      mode_q <= bus.mode;
  end

  assign dir = mode_q;
`else
  assign dir = 1'b0;
`endif

  assign last_beat = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_beat)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register, never from the inputs.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.out_data  = work;

  // Beat k works on nibbles k*SB_PER_CYC .. k*SB_PER_CYC+SB_PER_CYC-1.
  for (genvar g = 0; g < SB_PER_CYC; g++) begin : g_sb
    assign nib_idx[g] = NIB_IDX_W'((int'(cnt) * SB_PER_CYC + g) % NIBBLES);
    assign sb_in[g]   = work[{nib_idx[g], 2'b00} +: NIB_W];

    boron_sbox4 u_sbox4 (
      .din  (sb_in[g]),
      .dir  (dir),
      .dout (sb_out[g])
    );
  end

  always_comb begin
    work_nxt = work;
    for (int j = 0; j < SB_PER_CYC; j++)
      work_nxt[{nib_idx[j], 2'b00} +: NIB_W] = sb_out[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      work <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          work <= bus.in_data;
          cnt  <= '0;
        end
        RUN: begin
          work <= work_nxt;
          cnt  <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boron_sbox_seq.sv
// Bench for boron_sbox_seq: directed vectors, a per-cycle scoreboard model and an SB_PER_CYC sweep.
// Inverse vectors are exercised only when BORON_SBOX_INV_EN is defined.
module tb_boron_sbox_seq;

  localparam int N_MAIN = 4;

  logic clk;
  logic rst;

  boron_sbox_seq_if bus ();
  boron_sbox_seq_if bus1 ();
  boron_sbox_seq_if bus16 ();

  boron_sbox_seq #(.SB_PER_CYC(4))  dut   (.clk(clk), .rst(rst), .bus(bus));
  boron_sbox_seq #(.SB_PER_CYC(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  boron_sbox_seq #(.SB_PER_CYC(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk64(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endfunction

  function automatic void chk1(string nm, logic act, logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, required %b", nm, act, exp);
  endfunction

  function automatic void chk_int(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
  endfunction

  // Reference tables, written out independently of the design package.
  logic [3:0] fwd_t [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                             4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  logic [3:0] inv_t [16] = '{4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
                             4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB};

  function automatic logic [63:0] model_sub(logic [63:0] d, logic inv);
    logic [63:0] r;
    for (int i = 0; i < 16; i++)
      r[4*i +: 4] = inv ? inv_t[d[4*i +: 4]] : fwd_t[d[4*i +: 4]];
    return r;
  endfunction

  typedef struct {
    logic [63:0] exp;
    int          due;
  } item_t;

  item_t q[$];

  // Scoreboard: one operation in flight at most; result due N cycles after accept.
  always @(negedge clk) begin
    logic exp_valid;
    logic m;
`ifdef BORON_SBOX_INV_EN
    m = bus.mode;
`else
    m = 1'b0;
`endif
    if (rst) begin
      q.delete();
      chk1("mon rst out_valid", bus.out_valid, 1'b0);
      chk1("mon rst in_ready", bus.in_ready, 1'b1);
      chk1("mon rst busy", bus.busy, 1'b0);
      chk64("mon rst out_data", bus.out_data, 64'h0);
    end else begin
      exp_valid = (q.size() > 0) && (cyc >= q[0].due);
      chk1("mon out_valid", bus.out_valid, exp_valid);
      chk1("mon busy", bus.busy, q.size() > 0);
      chk1("mon in_ready", bus.in_ready, q.size() == 0);
      if (exp_valid) chk64("mon out_data", bus.out_data, q[0].exp);
      if (exp_valid && bus.out_ready)
        void'(q.pop_front());
      else if (q.size() == 0 && bus.in_valid)
        q.push_back('{exp: model_sub(bus.in_data, m), due: cyc + 1 + N_MAIN});
    end
  end

  task automatic do_op(input logic [63:0] d, input logic [63:0] e, input string nm);
    int k;
    logic seen;
    chk1({nm, " in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
`ifdef BORON_SBOX_INV_EN
    bus.mode = ~bus.mode;
`endif
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      seen = bus.out_valid;
    end
    chk_int({nm, " latency"}, k, N_MAIN);
    chk64({nm, " out_data"}, bus.out_data, e);
    @(posedge clk); #1;
    chk1({nm, " valid one cycle"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, l1, l16;
    logic seen;
    logic [63:0] d1, d16;

    rst = 1'b1;
    bus.in_valid = 1'b0;   bus.in_data = '0;   bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0;  bus1.in_data = '0;  bus1.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.out_ready = 1'b1;
`ifdef BORON_SBOX_INV_EN
    bus.mode = 1'b0; bus1.mode = 1'b0; bus16.mode = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk1("reset in_ready", bus.in_ready, 1'b1);
    chk1("reset out_valid", bus.out_valid, 1'b0);
    chk1("reset busy", bus.busy, 1'b0);
    chk64("reset out_data", bus.out_data, 64'h0);
    rst = 1'b0;

    // Sweep: SB_PER_CYC=1 and 16 on the first vector.
    @(posedge clk); #1;
    bus1.in_valid = 1'b1;  bus1.in_data = 64'h0123456789ABCDEF;
    bus16.in_valid = 1'b1; bus16.in_data = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;  bus1.in_data = '0;
    bus16.in_valid = 1'b0; bus16.in_data = '0;
    l1 = -1; l16 = -1; d1 = '0; d16 = '0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (bus1.out_valid && l1 < 0) begin l1 = i; d1 = bus1.out_data; end
      if (bus16.out_valid && l16 < 0) begin l16 = i; d16 = bus16.out_data; end
    end
    chk_int("sweep1 latency", l1, 16);
    chk64("sweep1 out_data", d1, 64'hE4B179CAD20F8536);
    chk_int("sweep16 latency", l16, 1);
    chk64("sweep16 out_data", d16, 64'hE4B179CAD20F8536);

    do_op(64'h0123456789ABCDEF, 64'hE4B179CAD20F8536, "fwd");
    do_op(64'h0000000000000000, 64'hEEEEEEEEEEEEEEEE, "zero");
`ifdef BORON_SBOX_INV_EN
    bus.mode = 1'b1;
    do_op(64'hE4B179CAD20F8536, 64'h0123456789ABCDEF, "inv");
    bus.mode = 1'b0;
`endif

    // Backpressure: hold out_ready low for 5 cycles, with a stray request mid-window.
    bus.out_ready = 1'b0;
    chk1("bp in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      seen = bus.out_valid;
    end
    chk_int("bp latency", k, N_MAIN);
    for (int i = 0; i < 5; i++) begin
      chk1("bp hold out_valid", bus.out_valid, 1'b1);
      chk64("bp hold out_data", bus.out_data, 64'hE4B179CAD20F8536);
      chk1("bp hold in_ready", bus.in_ready, 1'b0);
      bus.in_valid = (i == 2);
      bus.in_data  = 64'hFFFFFFFFFFFFFFFF;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk1("bp still valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("bp retired out_valid", bus.out_valid, 1'b0);
    chk1("bp retired in_ready", bus.in_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk1("bp stray ignored busy", bus.busy, 1'b0);

    // Reset during beat 2.
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("midrst out_valid", bus.out_valid, 1'b0);
    chk1("midrst in_ready", bus.in_ready, 1'b1);
    chk1("midrst busy", bus.busy, 1'b0);
    chk64("midrst out_data", bus.out_data, 64'h0);
    rst = 1'b0;
    do_op(64'hFFFFFFFFFFFFFFFF, 64'h6666666666666666, "after_rst");

    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
